// File: rtl/usb_crc_engine_pkg.sv
// Shared types and polynomial constants for the USB serial CRC engine.
package usb_crc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    EMIT,
    CRCIN,
    DONE
  } state_t;

  localparam logic [4:0]  CRC5_POLY     = 5'b00101;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

endpackage

// File: rtl/usb_crc_engine_lfsr.sv
// Serial CRC shift register: MSB-out feedback, loads all ones on init.
module crc_lfsr #(
  parameter int             CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(5'b00101)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             step,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '1;
    end else if (init) begin
      crc <= '1;
    end else if (step) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/usb_crc_engine.sv
// Parametrised USB CRC5/CRC16 generate/check engine with serial I/O.
// Optional failure counter on err_cnt is built when USB_CRC_ERR_CNT_EN is defined.
module usb_crc_engine
  import usb_crc_pkg::*;
#(
  parameter int               CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC5_POLY),
  parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(CRC5_RESIDUE),
  parameter int               LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             out_ready,
  output logic             crc_out,
  output logic             crc_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [7:0]       err_cnt
);

  localparam int               IDX_W    = (CRC_W > 1) ? $clog2(CRC_W) : 1;
  localparam logic [LEN_W-1:0] CRC_LAST = LEN_W'(CRC_W - 1);

  state_t           state_q, state_d;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             crc_ok_q;
  logic [CRC_W-1:0] lfsr;
  logic [IDX_W-1:0] emit_idx;
  logic             start_take;
  logic             lfsr_step;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             ok_clr;
  logic             ok_load;
  logic             residue_hit;

  crc_lfsr #(
    .CRC_W(CRC_W),
    .POLY (POLY)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .init (start_take),
    .step (lfsr_step),
    .din  (s_in),
    .crc  (lfsr)
  );

  assign residue_hit = (lfsr == RESIDUE);
  assign emit_idx    = IDX_W'(CRC_LAST - cnt_q);
  assign crc_out     = crc_valid & ~lfsr[emit_idx];
  assign busy        = (state_q != IDLE);
  assign crc_ok      = crc_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort wins over everything, including a start in the same cycle
  always_comb begin
    state_d    = state_q;
    start_take = 1'b0;
    lfsr_step  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    ok_clr     = 1'b0;
    ok_load    = 1'b0;
    crc_valid  = 1'b0;
    done       = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
      ok_clr  = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            start_take = 1'b1;
            cnt_clr    = 1'b1;
            ok_clr     = 1'b1;
            if (len == '0) begin
              state_d = mode ? CRCIN : EMIT;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (s_valid) begin
            lfsr_step = 1'b1;
            if (cnt_q == (len_q - LEN_W'(1))) begin
              cnt_clr = 1'b1;
              state_d = mode_q ? CRCIN : EMIT;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        EMIT: begin
          crc_valid = 1'b1;
          if (out_ready) begin
            if (cnt_q == CRC_LAST) begin
              cnt_clr = 1'b1;
              state_d = DONE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        CRCIN: begin
          if (s_valid) begin
            lfsr_step = 1'b1;
            if (cnt_q == CRC_LAST) begin
              cnt_clr = 1'b1;
              state_d = DONE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        DONE: begin
          done    = 1'b1;
          ok_load = mode_q;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      crc_ok_q <= 1'b0;
    end else begin
      if (start_take) begin
        mode_q <= mode;
        len_q  <= len;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (ok_clr) begin
        crc_ok_q <= 1'b0;
      end else if (ok_load) begin
        crc_ok_q <= residue_hit;
      end
    end
  end

`ifdef USB_CRC_ERR_CNT_EN
  logic [7:0] err_q;

  // saturating; only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'h00;
    end else if (ok_load && !residue_hit && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'h01;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: doc/usb_crc_engine.md
Name: usb_crc_engine

Overview:
Parametrised serial CRC engine for the USB link layer; next generation of the fixed 11-bit CRC5 token generator.
- Covers CRC5 (tokens) and CRC16 (data payloads) from one RTL body, selected by parameters.
- Supports a variable bit count per packet.
- Has two modes: generate (serially emits the complemented CRC) and check (verifies the received CRC against the USB residual).
- Sits between the bit-unstuffer/stuffer and the packet FSMs; s_valid absorbs stuff-bit stalls.

Parameters:
- CRC_W, 5, CRC width (5 or 16).
- POLY, 5'b00101, generator polynomial without the x^CRC_W term (CRC16: 16'h8005).
- RESIDUE, 5'b01100, good-packet residual (CRC16: 16'h800D).
- LEN_W, 11, width of the len port and bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches mode and len, loads the LFSR to all ones
- mode  in  1  0 = generate, 1 = check
- len  in  LEN_W  number of data bits that precede the CRC field
- abort  in  1  synchronous cancel to IDLE
- s_in  in  1  serial data bit, LSB-first wire order
- s_valid  in  1  s_in qualifier
- out_ready  in  1  consumer accepts crc_out this cycle
- crc_out  out  1  emitted CRC bit
- crc_valid  out  1  crc_out is valid
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse
- crc_ok  out  1  check result, held until the next start
- err_cnt  out  8  check-failure counter (optional feature)

Behaviour:
- Reset: state IDLE, LFSR all ones, counter 0. Outputs crc_out, crc_valid, busy, done, crc_ok all 0; err_cnt 0.
- LFSR step, applied only on an accepted bit:
  - fb = lfsr[CRC_W-1] ^ s_in
  - lfsr <= {lfsr[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
- IDLE:
  - start: load the LFSR to all ones, latch mode and len, clear the counter and crc_ok.
  - If len==0, go to EMIT (mode 0) or CRCIN (mode 1); otherwise go to DATA.
  - start while busy is ignored.
- DATA:
  - Each s_valid cycle steps the LFSR and increments the counter; s_valid low stalls.
  - On the cycle the counter reaches len-1 with s_valid high: clear the counter and go to EMIT or CRCIN.
  - s_valid is ignored in IDLE, EMIT and DONE.
- EMIT (generate mode):
  - crc_valid=1 and crc_out=~lfsr[CRC_W-1-cnt], i.e. complemented CRC, MSB of the register first.
  - Counter advances only when crc_valid && out_ready. Output holds stable while out_ready is low.
  - After CRC_W accepted bits, go to DONE.
- CRCIN (check mode):
  - Receive CRC_W more s_valid bits through the same LFSR step, then go to DONE.
- DONE (one cycle):
  - done=1.
  - In check mode, crc_ok <= (lfsr==RESIDUE) with no complement.
  - Return to IDLE.
- Latency: done is asserted 1 cycle after the last accepted CRC bit.
- Generate-mode total: len + CRC_W accepted bits, plus 1 cycle for DONE.
- abort (or rst_n) mid-operation:
  - Return to IDLE in the next cycle; no done pulse; crc_ok cleared; crc_valid drops immediately.
  - abort has priority over start in the same cycle.
- Counter is LEN_W bits and never wraps: len ≤ 2^LEN_W−1 by construction; the CRC phase counts to CRC_W-1 only.

Optional Feature:
- USB_CRC_ERR_CNT_EN defined: err_cnt is an 8-bit counter incremented in DONE when mode=1 and the residual mismatches. It saturates at 8'hFF, is cleared only by rst_n, and is unaffected by abort.
- Not defined: err_cnt is tied to 8'h00 and no counter flops are built.

Decomposition:
- Package usb_crc_pkg holds:
  - state enum {IDLE, DATA, EMIT, CRCIN, DONE}
  - constants CRC5_POLY=5'b00101, CRC5_RESIDUE=5'b01100, CRC16_POLY=16'h8005, CRC16_RESIDUE=16'h800D
- One sub-module, crc_lfsr, parametrised by CRC_W/POLY: ports init (load all ones), step, din, state out.
- FSM, counter and output mux stay in usb_crc_engine.

Test Plan:
- CRC5 generate, start mode=0 len=11, s_in eleven 0s (addr 0, endp 0) with s_valid=1 → crc_out stream 0,1,0,0,0 (field 5'h02), then done pulse; total 11+5+1 cycles.
- CRC5 check, len=11, eleven 0s then 0,1,0,0,0 → lfsr==5'b01100, crc_ok=1. Flip the 3rd CRC bit → crc_ok=0 and err_cnt 0→1 when USB_CRC_ERR_CNT_EN is defined.
- CRC16 instance (CRC_W=16), generate, len=0 → 16 emitted bits all 0 (zero-length DATA CRC 16'h0000); check of 16 zeros → crc_ok=1.
- Backpressure and stalls: out_ready low for 3 cycles mid-EMIT → crc_out held, no bit lost. s_valid toggling every other cycle in DATA → same CRC as contiguous input.
- abort asserted at DATA bit 5 → IDLE next cycle, busy=0, no done. A following start with len=11 gives the correct CRC.
- start while busy ignored; start and abort in the same cycle → stays IDLE. rst_n asserted during EMIT → all outputs 0 asynchronously.
